// File: rtl/gen_chan_pipe.sv
// Multi-channel register pipe.
// Each channel is an independent chain of DEPTH stages. Stage 0 faces the
// input and stage DEPTH-1 drives the output. MODE selects the behaviour:
// 0 is a free-running shift register, and 1 is an elastic valid/ready pipe
// that collapses bubbles. When DEPTH is 0 the block is a straight wire.
module gen_chan_pipe #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int MODE   = 1,
    localparam int CW    = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH*CW-1:0]    occ
);

    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("gen_chan_pipe: MODE must be 0 or 1");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        if (DEPTH == 0) begin : g_comb
            assign out_valid[c]               = in_valid[c];
            assign out_data[c*WIDTH +: WIDTH] = in_data[c*WIDTH +: WIDTH];
            assign in_ready[c]                = (MODE == 1) ? out_ready[c] : 1'b1;
            assign occ[c*CW +: CW]            = '0;
        end else begin : g_pipe
            logic [DEPTH-1:0]            v_q;
            logic [DEPTH-1:0]            v_d;
            logic [DEPTH-1:0]            en;
            logic [DEPTH-1:0][WIDTH-1:0] d_q;
            logic [DEPTH-1:0][WIDTH-1:0] d_d;
            logic [CW-1:0]               occ_c;

            // en[k] means that stage k loads from its upstream neighbour on this edge.
            case (MODE)
                0: begin : g_shift
                    assign en          = '1;
                    assign in_ready[c] = 1'b1;
                end
                1: begin : g_elastic
                    logic full_tail;

                    // A stage may load if the output drains or any stage at or after it is empty.
                    always_comb begin
                        full_tail = 1'b1;
                        en        = '0;
                        for (int k = DEPTH - 1; k >= 0; k--) begin
                            full_tail = full_tail & v_q[k];
                            en[k]     = out_ready[c] | ~full_tail;
                        end
                    end

                    // Stages are cleared by reset, so ready is forced high while it is asserted.
                    assign in_ready[c] = rst | en[0];
                end
                default: begin : g_none
                    assign en          = '0;
                    assign in_ready[c] = 1'b0;
                end
            endcase

            // Next-state: each enabled stage takes its upstream neighbour's content.
            always_comb begin
                v_d = v_q;
                d_d = d_q;
                if (en[0]) begin
                    v_d[0] = in_valid[c];
                    d_d[0] = in_data[c*WIDTH +: WIDTH];
                end
                for (int k = 1; k < DEPTH; k++) begin
                    if (en[k]) begin
                        v_d[k] = v_q[k-1];
                        d_d[k] = d_q[k-1];
                    end
                end
            end

            // Stage registers with a synchronous clear.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= '0;
                    d_q <= '0;
                end else begin
                    v_q <= v_d;
                    d_q <= d_d;
                end
            end

            // Occupancy is the population count of the stage valids.
            always_comb begin
                occ_c = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    occ_c = occ_c + CW'(v_q[k]);
                end
            end

            assign out_valid[c]               = v_q[DEPTH-1];
            assign out_data[c*WIDTH +: WIDTH] = d_q[DEPTH-1];
            assign occ[c*CW +: CW]            = occ_c;
        end
    end

endmodule

// File: tb/tb_gen_chan_pipe.sv
// Testbench for gen_chan_pipe. It builds four instances: a MODE 0 pipe with
// DEPTH 3, a MODE 1 pipe with DEPTH 2, and DEPTH 0 wires in both modes.
// Monitor processes act as a scoreboard and compare every item that comes out.
module tb_gen_chan_pipe;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } m0_item_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    // MODE 0, DEPTH 3
    logic [1:0]  m0_in_valid, m0_in_ready, m0_out_valid, m0_out_ready;
    logic [15:0] m0_in_data, m0_out_data;
    logic [3:0]  m0_occ;
    // MODE 1, DEPTH 2
    logic [1:0]  m1_in_valid, m1_in_ready, m1_out_valid, m1_out_ready;
    logic [15:0] m1_in_data, m1_out_data;
    logic [3:0]  m1_occ;
    // DEPTH 0: the two instances share their inputs
    logic [1:0]  d0_in_valid, d0_out_ready;
    logic [15:0] d0_in_data;
    logic [1:0]  c0_in_ready, c0_out_valid, c1_in_ready, c1_out_valid;
    logic [15:0] c0_out_data, c1_out_data;
    logic [1:0]  c0_occ, c1_occ;

    m0_item_t   q0[$];
    logic [7:0] q10[$];
    logic [7:0] q11[$];
    int m0_seen = 0, m1_seen0 = 0, m1_seen1 = 0;

    gen_chan_pipe #(.NUM_CH(2), .WIDTH(8), .DEPTH(3), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
        .in_data(m0_in_data), .out_valid(m0_out_valid), .out_ready(m0_out_ready),
        .out_data(m0_out_data), .occ(m0_occ));

    gen_chan_pipe #(.NUM_CH(2), .WIDTH(8), .DEPTH(2), .MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .in_valid(m1_in_valid), .in_ready(m1_in_ready),
        .in_data(m1_in_data), .out_valid(m1_out_valid), .out_ready(m1_out_ready),
        .out_data(m1_out_data), .occ(m1_occ));

    gen_chan_pipe #(.NUM_CH(2), .WIDTH(8), .DEPTH(0), .MODE(0)) u_c0 (
        .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(c0_in_ready),
        .in_data(d0_in_data), .out_valid(c0_out_valid), .out_ready(d0_out_ready),
        .out_data(c0_out_data), .occ(c0_occ));

    gen_chan_pipe #(.NUM_CH(2), .WIDTH(8), .DEPTH(0), .MODE(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(c1_in_ready),
        .in_data(d0_in_data), .out_valid(c1_out_valid), .out_ready(d0_out_ready),
        .out_data(c1_out_data), .occ(c1_occ));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: push accepted items and pop/compare delivered ones. Reset discards everything in flight.
    always @(negedge clk) begin
        m0_item_t e;
        if (rst) begin
            q0.delete();
            q10.delete();
            q11.delete();
        end else begin
            if (m0_in_valid[0]) begin
                e.cyc = cyc;
                e.d   = m0_in_data[7:0];
                q0.push_back(e);
            end
            if (m1_in_valid[0] && m1_in_ready[0]) q10.push_back(m1_in_data[7:0]);
            if (m1_in_valid[1] && m1_in_ready[1]) q11.push_back(m1_in_data[15:8]);

            if (m0_out_valid[0]) begin
                m0_seen++;
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check("m0_data", m0_out_data[7:0], e.d);
                    check("m0_latency", cyc - e.cyc, 3);
                end else begin
                    total_cnt++;
                    $display("FAIL m0_extra_item: got %0h expected no item", m0_out_data[7:0]);
                end
            end
            if (m1_out_valid[0] && m1_out_ready[0]) begin
                m1_seen0++;
                if (q10.size() > 0) check("m1_ch0_data", m1_out_data[7:0], q10.pop_front());
                else begin
                    total_cnt++;
                    $display("FAIL m1_ch0_extra_item: got %0h expected no item", m1_out_data[7:0]);
                end
            end
            if (m1_out_valid[1] && m1_out_ready[1]) begin
                m1_seen1++;
                if (q11.size() > 0) check("m1_ch1_data", m1_out_data[15:8], q11.pop_front());
                else begin
                    total_cnt++;
                    $display("FAIL m1_ch1_extra_item: got %0h expected no item", m1_out_data[15:8]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int vcnt;
        int rcnt;
        rst = 1'b1;
        m0_in_valid = '0; m0_in_data = '0; m0_out_ready = '0;
        m1_in_valid = '0; m1_in_data = '0; m1_out_ready = 2'b11;
        d0_in_valid = '0; d0_in_data = '0; d0_out_ready = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("in_ready_during_rst", m1_in_ready, 2'b11);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_m1_out_valid", m1_out_valid, 2'b00);
        check("rst_m1_out_data", m1_out_data, 16'h0000);
        check("rst_m1_occ", m1_occ, 4'h0);
        check("rst_m1_in_ready", m1_in_ready, 2'b11);
        check("rst_m0_out_valid", m0_out_valid, 2'b00);
        check("rst_m0_occ", m0_occ, 4'h0);

        // MODE 0: 0x11, 0x22, 0x33 appear 3 cycles later. out_ready=0 is ignored.
        m0_in_valid = 2'b01; m0_in_data = 16'h0011;
        @(posedge clk); #1; m0_in_data = 16'h0022;
        @(posedge clk); #1; m0_in_data = 16'h0033;
        @(posedge clk); #1; m0_in_valid = 2'b00; m0_in_data = 16'h0000;
        repeat (5) @(posedge clk);
        #1;
        check("m0_items_out", m0_seen, 3);
        check("m0_in_ready", m0_in_ready, 2'b11);
        check("m0_drained_occ", m0_occ, 4'h0);

        // MODE 1: stall ch0 and push 3 items. Only the first 2 are accepted.
        m1_out_ready = 2'b10;
        m1_in_valid  = 2'b01; m1_in_data = 16'h00A1;
        @(posedge clk); #1; m1_in_data = 16'h00A2;
        @(posedge clk); #1; m1_in_data = 16'h00A3;
        check("stall_occ", m1_occ[1:0], 2'd2);
        check("stall_in_ready", m1_in_ready[0], 1'b0);
        check("stall_out_data", m1_out_data[7:0], 8'hA1);
        repeat (2) @(posedge clk);
        #1;
        check("stall_hold_occ", m1_occ[1:0], 2'd2);
        check("stall_hold_data", m1_out_data[7:0], 8'hA1);
        check("stall_hold_valid", m1_out_valid[0], 1'b1);

        // Full pipe streaming: accept and emit one item per cycle, occupancy stays 2.
        m1_out_ready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            m1_in_data = 16'(8'hA3 + i);
            @(posedge clk);
            #1;
            check("full_stream_occ", m1_occ[1:0], 2'd2);
        end
        m1_in_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("full_stream_items", m1_seen0, 7);
        check("full_stream_empty", m1_occ[1:0], 2'd0);

        // Channel independence: ch1 fills and stalls while ch0 streams 0x00..0x0F.
        m1_out_ready = 2'b01;
        vcnt = 0;
        rcnt = 0;
        for (int i = 0; i < 17; i++) begin
            m1_in_valid[0] = (i < 16);
            m1_in_data[7:0] = (i < 16) ? 8'(i) : 8'h00;
            m1_in_valid[1] = (i < 2);
            m1_in_data[15:8] = (i == 0) ? 8'hB1 : 8'hB2;
            #1;
            if (i < 16 && m1_in_ready[0]) rcnt++;
            @(posedge clk);
            #1;
            if (m1_out_valid[0]) vcnt++;
        end
        m1_in_valid = 2'b00;
        check("indep_ch0_ready_cycles", rcnt, 16);
        check("indep_ch0_gapless", vcnt, 16);
        check("indep_ch1_occ", m1_occ[3:2], 2'd2);
        check("indep_ch1_in_ready", m1_in_ready[1], 1'b0);
        check("indep_ch1_head", m1_out_data[15:8], 8'hB1);
        m1_out_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("indep_ch0_items", m1_seen0, 23);
        check("indep_ch1_items", m1_seen1, 2);

        // Reset mid-stream with occupancy 2
        m1_out_ready = 2'b10;
        m1_in_valid  = 2'b01; m1_in_data = 16'h00C1;
        @(posedge clk); #1; m1_in_data = 16'h00C2;
        @(posedge clk); #1; m1_in_data = 16'h00C3;
        check("pre_rst_occ", m1_occ[1:0], 2'd2);
        rst = 1'b1;
        #1;
        check("rst_forces_ready", m1_in_ready[0], 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m1_in_valid = 2'b00;
        check("midrst_out_valid", m1_out_valid, 2'b00);
        check("midrst_occ", m1_occ, 4'h0);
        check("midrst_in_ready", m1_in_ready, 2'b11);
        check("midrst_out_data", m1_out_data, 16'h0000);
        m1_out_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_emit", m1_seen0, 23);

        // DEPTH 0: combinational pass-through in both modes
        d0_in_data = 16'h5A3C; d0_in_valid = 2'b01; d0_out_ready = 2'b10;
        #1;
        check("d0_m0_data", c0_out_data, 16'h5A3C);
        check("d0_m0_valid", c0_out_valid, 2'b01);
        check("d0_m0_ready", c0_in_ready, 2'b11);
        check("d0_m1_data", c1_out_data, 16'h5A3C);
        check("d0_m1_ready", c1_in_ready, 2'b10);
        check("d0_occ", {c1_occ, c0_occ}, 4'h0);
        d0_in_data = 16'hC3F0; d0_in_valid = 2'b10; d0_out_ready = 2'b01;
        #1;
        check("d0_m0_data2", c0_out_data, 16'hC3F0);
        check("d0_m0_ready2", c0_in_ready, 2'b11);
        check("d0_m1_data2", c1_out_data, 16'hC3F0);
        check("d0_m1_valid2", c1_out_valid, 2'b10);
        check("d0_m1_ready2", c1_in_ready, 2'b01);

        repeat (2) @(posedge clk);
        #1;
        check("q0_empty", q0.size(), 0);
        check("q10_empty", q10.size(), 0);
        check("q11_empty", q11.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
